// File: rtl/pio_cmd_if.sv
// Host-command and pio-bus signal bundle for pio_cmd_sequencer.
// The master side is the host/bench; the slave side is the sequencer.
interface pio_cmd_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_action;
    logic [1:0]  cmd_mindex;
    logic [31:0] cmd_data;
    logic        hold;
    logic [3:0]  pio_action;
    logic [1:0]  pio_mindex;
    logic [4:0]  pio_index;
    logic [31:0] pio_din;

    modport master (
        output cmd_valid, cmd_action, cmd_mindex, cmd_data, hold,
        input  cmd_ready, pio_action, pio_mindex, pio_index, pio_din
    );

    modport slave (
        input  cmd_valid, cmd_action, cmd_mindex, cmd_data, hold,
        output cmd_ready, pio_action, pio_mindex, pio_index, pio_din
    );
endinterface

// File: rtl/pio_cmd_sequencer.sv
// Queues host PIO commands in a small FIFO and replays them onto the pio
// command bus as single-cycle pulses, tracking the instruction index itself.
module pio_cmd_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int IMEM_WORDS = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    pio_cmd_if.slave    bus,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [5:0]  prog_len
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0] ZERO_CNT = {(PTR_W + 1){1'b0}};
    localparam logic [5:0]     IMEM_LIMIT = 6'(IMEM_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_STALL = 2'd2
    } state_e;

    logic [37:0]      mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             rdy_q, rdy_d;
    state_e           state_q, state_d;
    logic [3:0]       act_q, act_d;
    logic [1:0]       mindex_q, mindex_d;
    logic [4:0]       index_q, index_d;
    logic [31:0]      din_q, din_d;
    logic [5:0]       pcnt_q, pcnt_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             push_s, pop_s;
    logic [3:0]       head_action_s;
    logic [1:0]       head_mindex_s;
    logic [31:0]      head_data_s;

    assign push_s = bus.cmd_valid && rdy_q;
    assign {head_action_s, head_mindex_s, head_data_s} = mem_q[rd_ptr_q];

    // FSM next state and pop decision; ISSUE/STALL mean the FIFO holds entries
    always_comb begin
        pop_s   = 1'b0;
        state_d = state_q;
        case (state_q)
            ST_IDLE:  pop_s = 1'b0;
            ST_ISSUE: pop_s = !bus.hold;
            ST_STALL: pop_s = !bus.hold;
            default:  pop_s = 1'b0;
        endcase
        if (count_d == ZERO_CNT) begin
            state_d = ST_IDLE;
        end else if (bus.hold) begin
            state_d = ST_STALL;
        end else begin
            state_d = ST_ISSUE;
        end
    end

    // FIFO pointer/occupancy bookkeeping; ready is registered from the next count
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push_s);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_s);
        count_d  = count_q + (PTR_W + 1)'(push_s) - (PTR_W + 1)'(pop_s);
        rdy_d    = (count_d != FULL_CNT);
    end

    // Decode the popped head into a bus pulse and update index counter / error
    always_comb begin
        act_d    = 4'd0;
        mindex_d = mindex_q;
        index_d  = index_q;
        din_d    = din_q;
        pcnt_d   = pcnt_q;
        err_d    = err_q;
        if (pop_s) begin
            case (head_action_s)
                4'd0: begin
                    if (head_data_s[0]) begin
                        pcnt_d = 6'd0;
                        err_d  = 1'b0;
                    end else begin
                        pcnt_d = pcnt_q;
                    end
                end
                4'd1: begin
                    if (pcnt_q == IMEM_LIMIT) begin
                        err_d = 1'b1;
                    end else begin
                        act_d    = 4'd1;
                        mindex_d = head_mindex_s;
                        index_d  = pcnt_q[4:0];
                        din_d    = {16'h0000, head_data_s[15:0]};
                        pcnt_d   = pcnt_q + 6'd1;
                    end
                end
                default: begin
                    act_d    = head_action_s;
                    mindex_d = head_mindex_s;
                    index_d  = 5'd0;
                    din_d    = head_data_s;
                end
            endcase
        end else begin
            act_d = 4'd0;
        end
        busy_d = (count_d != ZERO_CNT) || (act_d != 4'd0);
        done_d = busy_q && !busy_d;
    end

    // FIFO storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {bus.cmd_action, bus.cmd_mindex, bus.cmd_data};
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= ZERO_CNT;
            rdy_q    <= 1'b0;
            state_q  <= ST_IDLE;
            act_q    <= 4'd0;
            mindex_q <= 2'd0;
            index_q  <= 5'd0;
            din_q    <= 32'd0;
            pcnt_q   <= 6'd0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rdy_q    <= rdy_d;
            state_q  <= state_d;
            act_q    <= act_d;
            mindex_q <= mindex_d;
            index_q  <= index_d;
            din_q    <= din_d;
            pcnt_q   <= pcnt_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.cmd_ready  = rdy_q;
    assign bus.pio_action = act_q;
    assign bus.pio_mindex = mindex_q;
    assign bus.pio_index  = index_q;
    assign bus.pio_din    = din_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;
    assign prog_len       = pcnt_q;
endmodule

// File: doc/pio_cmd_sequencer.md
Name: pio_cmd_sequencer

Overview:
- Buffers host-issued PIO commands (program words and config writes) and replays them onto the pio command bus (action/mindex/index/din) as single-cycle pulses, one per clock maximum.
- Replaces hardwired program/config ROM sequencing in top-level designs; sits between a host port (UART/SPI bridge or boot ROM walker) and the pio instance.
- Owns the instruction-index counter, so the host never supplies instruction addresses.

Parameters:
- FIFO_DEPTH, 4, command FIFO entries (power of 2, >=2)
- IMEM_WORDS, 32, pio instruction memory size; index counter wraps to error beyond this

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  FIFO can accept (not full)
- cmd_action  in  4  pio action code
- cmd_mindex  in  2  target state machine
- cmd_data  in  32  instruction word (low 16 bits) or config value
- hold  in  1  stall issue; FIFO still fills
- pio_action  out  4  to pio action; 0 = idle
- pio_mindex  out  2  to pio mindex
- pio_index  out  5  to pio index
- pio_din  out  32  to pio din
- busy  out  1  FIFO non-empty or issue in flight
- done  out  1  one-cycle pulse when sequence drains
- err  out  1  sticky instruction-index overflow
- prog_len  out  6  instructions written since last index clear

Behaviour:
- Reset (async, reset_n low): FIFO empty, all outputs 0, cmd_ready=0 while in reset then 1; index counter 0, err 0. Reset mid-sequence discards all queued commands; pio sees action 0 from that instant.
- Accept on rising edge when cmd_valid && cmd_ready. cmd_ready = !full (registered count, no same-cycle pop bypass).
- Simultaneous push+pop when full: push refused (cmd_ready=0); pop proceeds.
- States:
  - IDLE: FIFO empty.
  - ISSUE: FIFO non-empty && !hold; pop head each edge.
  - STALL: hold=1 with FIFO non-empty; pio_action=0, no pop.
  - Transitions are evaluated every edge.
- Issue timing: head popped at edge E; pio_action/mindex/index/din are registered at E and valid for exactly cycle E..E+1. At the next edge, if nothing is popped, pio_action returns to 0. mindex, index and din hold their last values.
- Latency: command accepted at edge k into an empty FIFO with hold=0 is popped at edge k+1. Sustained throughput is 1 command per clock.
- Action 1 (write instruction):
  - pio_index = index counter; pio_din = {16'h0, cmd_data[15:0]}.
  - Counter increments after issue; prog_len = counter.
  - If counter == IMEM_WORDS: command is dropped (pio_action stays 0), err set, counter unchanged.
- Action 0 with cmd_data[0]=1 (index clear): not forwarded to pio; counter=0, prog_len=0, err=0. Action 0 with cmd_data[0]=0 is a NOP consuming one slot; pio_action stays 0.
- All other actions (2 wrap, 5 pins, 6 enable, 7 divider, 8 sideset, 3/4 irq/other): forwarded verbatim. pio_index = 0; din = cmd_data; mindex = cmd_mindex.
- Ordering: strictly FIFO; no reordering or coalescing.
- busy = (FIFO count != 0) || (pio_action != 0).
- done: single pulse the cycle busy falls 1->0. Never asserted directly out of reset.
- hold asserted in the same cycle the head would pop: no pop. Releasing hold resumes at the next edge.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap modulo depth; the count is one bit wider.

Test Plan:
- Push 4 action-1 words 0xE081, 0xE101, 0xE000, 0x0001 back-to-back, hold=0 -> pio_action=1 for 4 consecutive cycles with pio_index 0,1,2,3 and din low half matching; prog_len=4; done pulses once.
- Push 5 commands while hold=1, FIFO_DEPTH=4 -> cmd_ready low after 4th accept; 5th held off by host; release hold -> 4 issues in order, then the 5th is accepted and issued.
- Push 32 instructions, then a 33rd -> 33rd never appears on pio bus, err=1, prog_len=32; push action 0 data 1 -> err=0, prog_len=0; next instruction goes to index 0.
- Push config sequence (2,0x3),(7,0x280),(5,0x1),(8,0x0),(6,0x1) with mindex=2 -> five single-cycle pulses, pio_index=0, mindex=2, din values exact.
- Pull reset_n low while 3 commands are queued -> pio_action=0 immediately (async), busy=0, done not pulsed; after release the FIFO is empty and the counter is 0.
- Push then pop in the same cycle at count 3 -> count stays 3, no lost or duplicated command.
